// File: rtl/lrf_pkg.sv
// Shared definitions for the frame buffer load/store unit.
//   - default image geometry (IMAGE_DIM, PIXEL_WIDTH, PIXELS_PER_BEAT, NUM_FRAMES)
//   - helpers deriving beat width and beats per frame from that geometry
//   - clog2 used for all pointer/counter widths
//   - read-side FSM state type
package lrf_pkg;

  localparam int LRF_IMAGE_DIM       = 512;
  localparam int LRF_PIXEL_WIDTH     = 8;
  localparam int LRF_PIXELS_PER_BEAT = 16;
  localparam int LRF_NUM_FRAMES      = 2;

  typedef enum logic [0:0] {
    RD_ISSUE = 1'b0,
    RD_HOLD  = 1'b1
  } rd_state_t;

  // Width needed to index 0..value-1. Floors at 1 so a single-entry
  // index (e.g. one frame slot) still gets a real bit.
  function automatic int clog2(input int value);
    int w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int data_width(input int pixel_width, input int pixels_per_beat);
    return pixel_width * pixels_per_beat;
  endfunction

  function automatic int beats_per_frame(input int image_dim, input int pixels_per_beat);
    return (image_dim * image_dim) / pixels_per_beat;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: DEPTH x WIDTH.
//   clk      : clock
//   wr_en    : write strobe, wr_data stored at wr_addr on the clock edge
//   rd_en    : read strobe, rd_data updated from rd_addr on the clock edge
//   rd_data  : registered read data (holds when rd_en=0)
// The array and read register carry no reset so the store maps onto block RAM.
module frame_ram #(
  parameter int DEPTH  = 2,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_buffer_lsu.sv
// Multi-frame image store. Pixel beats arrive on the s_* stream, whole frames
// are committed into NUM_FRAMES circular slots, and committed frames stream
// out on m_* with backpressure and optional replay of the same frame.
// Ports:
//   clk, aresetn        : clock, asynchronous active-low reset
//   flush               : synchronous clear of pointers, counts and output stage
//   s_valid/s_ready/s_data : write beat stream
//   m_valid/m_ready/m_data/m_last : read beat stream, m_last on final beat
//   rd_replay           : sampled with the m_last handshake, 1 = re-read frame
//   wr_frame_done       : one-cycle pulse after a frame commit
//   rd_frame_done       : one-cycle pulse after a frame release
//   frames_stored       : committed, unreleased frames
//
// Read issue FSM:
//   state    | meaning
//   RD_ISSUE | issue RAM reads for the current frame while a frame is stored
//            | and the skid buffer has room
//   RD_HOLD  | final beat issued; wait for the m_last handshake to learn
//            | whether the frame is released or replayed
module frame_buffer_lsu
  import lrf_pkg::*;
#(
  parameter int IMAGE_DIM       = LRF_IMAGE_DIM,
  parameter int PIXEL_WIDTH     = LRF_PIXEL_WIDTH,
  parameter int PIXELS_PER_BEAT = LRF_PIXELS_PER_BEAT,
  parameter int NUM_FRAMES      = LRF_NUM_FRAMES,
  localparam int DATA_WIDTH     = data_width(PIXEL_WIDTH, PIXELS_PER_BEAT),
  localparam int FS_W           = clog2(NUM_FRAMES + 1)
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  rd_replay,
  output logic                  wr_frame_done,
  output logic                  rd_frame_done,
  output logic [FS_W-1:0]       frames_stored
);

  localparam int BEATS  = beats_per_frame(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int DEPTH  = NUM_FRAMES * BEATS;
  localparam int BEAT_W = clog2(BEATS);
  localparam int SLOT_W = clog2(NUM_FRAMES);
  localparam int ADDR_W = clog2(DEPTH);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_FRAMES - 1);

  logic [BEAT_W-1:0]     wr_beat, rd_beat;
  logic [SLOT_W-1:0]     wr_slot, rd_slot;
  logic [FS_W-1:0]       frames_stored_q;
  rd_state_t             rd_state, rd_state_nxt;

  logic                  wr_fire, wr_commit;
  logic                  m_pop, last_pop, rd_release;
  logic                  rd_issue;
  logic                  ram_vld, ram_last;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [ADDR_W-1:0]     wr_addr, rd_addr;

  logic [DATA_WIDTH-1:0] sk_data [2];
  logic [1:0]            sk_last;
  logic                  sk_wp, sk_rp;
  logic [1:0]            sk_cnt;
  logic [2:0]            sk_occ;
  logic                  sk_room;

  assign s_ready    = (frames_stored_q < FS_W'(NUM_FRAMES));
  assign wr_fire    = s_valid & s_ready;
  assign wr_commit  = wr_fire & (wr_beat == LAST_BEAT);

  assign m_valid    = (sk_cnt != 2'd0);
  assign m_data     = sk_data[sk_rp];
  assign m_last     = sk_last[sk_rp];
  assign m_pop      = m_valid & m_ready;
  assign last_pop   = m_pop & m_last;
  assign rd_release = last_pop & ~rd_replay;

  assign frames_stored = frames_stored_q;

  // Occupancy the skid buffer will have once the read already in flight
  // lands and this cycle's pop retires; a new read is safe only below 2.
  assign sk_occ  = {1'b0, sk_cnt} + {2'b00, ram_vld} - {2'b00, m_pop};
  assign sk_room = (sk_occ < 3'd2);

  assign wr_addr = ADDR_W'(wr_slot) * ADDR_W'(BEATS) + ADDR_W'(wr_beat);
  assign rd_addr = ADDR_W'(rd_slot) * ADDR_W'(BEATS) + ADDR_W'(rd_beat);

  always_comb begin
    rd_state_nxt = rd_state;
    rd_issue     = 1'b0;
    case (rd_state)
      RD_ISSUE: begin
        if ((frames_stored_q != '0) && sk_room) begin
          rd_issue = 1'b1;
          if (rd_beat == LAST_BEAT) rd_state_nxt = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (last_pop) rd_state_nxt = RD_ISSUE;
      end
      default: rd_state_nxt = RD_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state        <= RD_ISSUE;
      wr_beat         <= '0;
      wr_slot         <= '0;
      rd_beat         <= '0;
      rd_slot         <= '0;
      frames_stored_q <= '0;
      wr_frame_done   <= 1'b0;
      rd_frame_done   <= 1'b0;
      ram_vld         <= 1'b0;
      ram_last        <= 1'b0;
    end else if (flush) begin
      rd_state        <= RD_ISSUE;
      wr_beat         <= '0;
      wr_slot         <= '0;
      rd_beat         <= '0;
      rd_slot         <= '0;
      frames_stored_q <= '0;
      wr_frame_done   <= 1'b0;
      rd_frame_done   <= 1'b0;
      ram_vld         <= 1'b0;
      ram_last        <= 1'b0;
    end else begin
      rd_state <= rd_state_nxt;

      if (wr_fire) begin
        if (wr_commit) begin
          wr_beat <= '0;
          wr_slot <= (wr_slot == LAST_SLOT) ? '0 : wr_slot + SLOT_W'(1);
        end else begin
          wr_beat <= wr_beat + BEAT_W'(1);
        end
      end

      if (rd_issue) rd_beat <= (rd_beat == LAST_BEAT) ? '0 : rd_beat + BEAT_W'(1);
      if (rd_release) rd_slot <= (rd_slot == LAST_SLOT) ? '0 : rd_slot + SLOT_W'(1);

      // Coincident commit and release cancel out.
      if (wr_commit && !rd_release)      frames_stored_q <= frames_stored_q + FS_W'(1);
      else if (!wr_commit && rd_release) frames_stored_q <= frames_stored_q - FS_W'(1);

      wr_frame_done <= wr_commit;
      rd_frame_done <= rd_release;
      ram_vld       <= rd_issue;
      ram_last      <= rd_issue & (rd_beat == LAST_BEAT);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sk_data[0] <= '0;
      sk_data[1] <= '0;
      sk_last    <= '0;
      sk_wp      <= 1'b0;
      sk_rp      <= 1'b0;
      sk_cnt     <= 2'd0;
    end else if (flush) begin
      sk_data[0] <= '0;
      sk_data[1] <= '0;
      sk_last    <= '0;
      sk_wp      <= 1'b0;
      sk_rp      <= 1'b0;
      sk_cnt     <= 2'd0;
    end else begin
      if (ram_vld) begin
        sk_data[sk_wp] <= ram_rdata;
        sk_last[sk_wp] <= ram_last;
        sk_wp          <= ~sk_wp;
      end
      if (m_pop) sk_rp <= ~sk_rp;
      case ({ram_vld, m_pop})
        2'b10:   sk_cnt <= sk_cnt + 2'd1;
        2'b01:   sk_cnt <= sk_cnt - 2'd1;
        default: sk_cnt <= sk_cnt;
      endcase
    end
  end

  frame_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (DATA_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_frame_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_addr),
    .wr_data (s_data),
    .rd_en   (rd_issue),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

endmodule

// File: tb/tb_frame_buffer_lsu.sv
// Directed bench for frame_buffer_lsu with 16-beat frames and two slots.
module tb_frame_buffer_lsu;

  localparam int BEATS = 16;
  localparam int DW    = 128;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          rd_replay;
  logic          wr_frame_done;
  logic          rd_frame_done;
  logic [1:0]    frames_stored;

  frame_buffer_lsu #(
    .IMAGE_DIM       (16),
    .PIXEL_WIDTH     (8),
    .PIXELS_PER_BEAT (16),
    .NUM_FRAMES      (2)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .flush         (flush),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .rd_replay     (rd_replay),
    .wr_frame_done (wr_frame_done),
    .rd_frame_done (rd_frame_done),
    .frames_stored (frames_stored)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_mis;
  int cyc;

  logic [DW-1:0] wq [$];
  logic [DW-1:0] rq [$];
  logic          rl [$];

  int            rmode;        // 0 never, 1 always, 2 random, 3 stall on last, 4 limit
  int            read_limit;
  logic          replay_arm;
  int            n_wr_done, n_rd_done;
  int            first_wrd_cyc, first_mv_cyc, first_pop_cyc, last_pop_cyc;
  int            rd_done_at_last;
  logic          sready_at_last, sready_at_rddone;
  logic          stall_prev;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  function automatic logic [DW-1:0] bv(input int tag, input int idx);
    return (DW'(tag) << 16) | DW'(idx);
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    wq.delete();
    rq.delete();
    rl.delete();
    n_wr_done = 0;
    n_rd_done = 0;
    first_wrd_cyc = -1;
    first_mv_cyc  = -1;
    first_pop_cyc = -1;
    last_pop_cyc  = -1;
    rd_done_at_last  = -1;
    sready_at_last   = 1'b1;
    sready_at_rddone = 1'b0;
    stall_prev = 1'b0;
    replay_arm = 1'b0;
    s_valid    = 1'b0;
    m_ready    = 1'b0;
    rd_replay  = 1'b0;
  endtask

  task automatic push_frame(input int tag, input int n);
    for (int i = 0; i < n; i++) wq.push_back(bv(tag, i));
  endtask

  // One clock: drive inputs from the queues/policy, log handshakes, advance.
  task automatic step();
    logic acc_w, acc_r;
    if (stall_prev) begin
      check("hold_valid", DW'(m_valid), DW'(1));
      check("hold_data", m_data, prev_data);
      check("hold_last", DW'(m_last), DW'(prev_last));
    end
    s_valid = (wq.size() != 0);
    s_data  = s_valid ? wq[0] : '0;
    case (rmode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      2:       m_ready = 1'($urandom_range(0, 1));
      3:       m_ready = !(m_valid && m_last);
      default: m_ready = (rq.size() < read_limit);
    endcase
    rd_replay = replay_arm;
    acc_w = s_valid && s_ready;
    acc_r = m_valid && m_ready;
    if (acc_r) begin
      rq.push_back(m_data);
      rl.push_back(m_last);
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      if (m_last) begin
        sready_at_last  = s_ready;
        rd_done_at_last = n_rd_done;
        replay_arm      = 1'b0;
      end
    end
    stall_prev = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clk);
    #1;
    cyc++;
    if (acc_w) void'(wq.pop_front());
    if (wr_frame_done) begin
      n_wr_done++;
      if (first_wrd_cyc < 0) first_wrd_cyc = cyc;
    end
    if (rd_frame_done) begin
      n_rd_done++;
      sready_at_rddone = s_ready;
    end
    if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
  endtask

  task automatic check_frame(input string tag, input int base, input int ftag);
    for (int i = 0; i < BEATS; i++) begin
      check($sformatf("%s_d%0d", tag, i), rq[base+i], bv(ftag, i));
      check($sformatf("%s_l%0d", tag, i), DW'(rl[base+i]), DW'(i == BEATS-1));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_s_ready"}, DW'(s_ready), DW'(1));
    check({tag, "_m_valid"}, DW'(m_valid), DW'(0));
    check({tag, "_m_data"}, m_data, DW'(0));
    check({tag, "_m_last"}, DW'(m_last), DW'(0));
    check({tag, "_stored"}, DW'(frames_stored), DW'(0));
    check({tag, "_wr_done"}, DW'(wr_frame_done), DW'(0));
    check({tag, "_rd_done"}, DW'(rd_frame_done), DW'(0));
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    cyc   = 0;
    aresetn = 1'b0;
    flush   = 1'b0;
    s_data  = '0;
    rmode   = 0;
    read_limit = 0;
    clear_sb();
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;
    check_idle("reset");

    // 1: single frame, data = beat index, free-flowing reader
    clear_sb();
    rmode = 1;
    push_frame(0, BEATS);
    for (int k = 0; k < 60 && n_rd_done == 0; k++) step();
    check("t1_count", DW'(rq.size()), DW'(BEATS));
    check_frame("t1", 0, 0);
    check("t1_wr_done", DW'(n_wr_done), DW'(1));
    check("t1_rd_done", DW'(n_rd_done), DW'(1));
    check("t1_first_valid_lat", DW'(first_mv_cyc - first_wrd_cyc), DW'(2));
    check("t1_burst_span", DW'(last_pop_cyc - first_pop_cyc), DW'(BEATS-1));
    check("t1_stored", DW'(frames_stored), DW'(0));

    // 2: fill both slots, third frame waits until A is released
    clear_sb();
    rmode = 0;
    push_frame(10, BEATS);
    push_frame(11, BEATS);
    push_frame(12, BEATS);
    repeat (40) step();
    check("t2_full_stored", DW'(frames_stored), DW'(2));
    check("t2_full_s_ready", DW'(s_ready), DW'(0));
    check("t2_third_held", DW'(wq.size()), DW'(BEATS));
    check("t2_head_valid", DW'(m_valid), DW'(1));
    check("t2_head_data", m_data, bv(10, 0));
    rmode = 1;
    for (int k = 0; k < 40 && n_rd_done == 0; k++) step();
    check("t2_s_ready_at_last", DW'(sready_at_last), DW'(0));
    check("t2_s_ready_after_rel", DW'(sready_at_rddone), DW'(1));
    for (int k = 0; k < 150 && rq.size() < 3*BEATS; k++) step();
    for (int k = 0; k < 20 && n_rd_done < 3; k++) step();
    check("t2_count", DW'(rq.size()), DW'(3*BEATS));
    check_frame("t2a", 0, 10);
    check_frame("t2b", BEATS, 11);
    check_frame("t2c", 2*BEATS, 12);
    check("t2_wr_done", DW'(n_wr_done), DW'(3));
    check("t2_rd_done", DW'(n_rd_done), DW'(3));
    check("t2_stored", DW'(frames_stored), DW'(0));

    // 3: random backpressure across two frames
    clear_sb();
    rmode = 2;
    push_frame(13, BEATS);
    push_frame(14, BEATS);
    for (int k = 0; k < 400 && rq.size() < 2*BEATS; k++) step();
    for (int k = 0; k < 20 && n_rd_done < 2; k++) step();
    check("t3_count", DW'(rq.size()), DW'(2*BEATS));
    check_frame("t3d", 0, 13);
    check_frame("t3e", BEATS, 14);
    check("t3_rd_done", DW'(n_rd_done), DW'(2));

    // 4: replay the first pass, release on the second
    clear_sb();
    rmode = 1;
    replay_arm = 1'b1;
    push_frame(15, BEATS);
    for (int k = 0; k < 120 && rq.size() < 2*BEATS; k++) step();
    repeat (4) step();
    check("t4_count", DW'(rq.size()), DW'(2*BEATS));
    check_frame("t4p1", 0, 15);
    check_frame("t4p2", BEATS, 15);
    check("t4_no_early_release", DW'(rd_done_at_last), DW'(0));
    check("t4_rd_done", DW'(n_rd_done), DW'(1));
    check("t4_stored", DW'(frames_stored), DW'(0));

    // 5: commit of B on the same edge as release of A
    clear_sb();
    rmode = 3;
    push_frame(16, BEATS);
    push_frame(17, BEATS-1);
    for (int k = 0; k < 80 && !(wq.size() == 0 && m_valid && m_last); k++) step();
    check("t5_pre_stored", DW'(frames_stored), DW'(1));
    check("t5_head_last", DW'(m_last), DW'(1));
    check("t5_head_data", m_data, bv(16, BEATS-1));
    s_valid   = 1'b1;
    s_data    = bv(17, BEATS-1);
    m_ready   = 1'b1;
    rd_replay = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("t5_wr_pulse", DW'(wr_frame_done), DW'(1));
    check("t5_rd_pulse", DW'(rd_frame_done), DW'(1));
    check("t5_stored", DW'(frames_stored), DW'(1));
    clear_sb();
    rmode = 1;
    for (int k = 0; k < 60 && rq.size() < BEATS; k++) step();
    check("t5_count", DW'(rq.size()), DW'(BEATS));
    check_frame("t5b", 0, 17);

    // 6: asynchronous reset mid-frame
    clear_sb();
    rmode = 4;
    read_limit = 4;
    push_frame(18, BEATS);
    for (int k = 0; k < 40 && n_wr_done == 0; k++) step();
    push_frame(19, 8);
    for (int k = 0; k < 40 && !(wq.size() == 0 && rq.size() >= 4); k++) step();
    check("t6_read_count", DW'(rq.size()), DW'(4));
    check("t6_beat3", rq[3], bv(18, 3));
    check("t6_stored", DW'(frames_stored), DW'(1));
    #2;
    aresetn = 1'b0;
    #1;
    check_idle("t6_async");
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    clear_sb();
    rmode = 1;
    push_frame(20, BEATS);
    for (int k = 0; k < 60 && rq.size() < BEATS; k++) step();
    check("t6_count", DW'(rq.size()), DW'(BEATS));
    check_frame("t6j", 0, 20);

    // 7: synchronous flush with a frame stored and the output stage loaded
    clear_sb();
    rmode = 0;
    push_frame(21, BEATS);
    repeat (22) step();
    check("t7_pre_stored", DW'(frames_stored), DW'(1));
    check("t7_pre_valid", DW'(m_valid), DW'(1));
    flush = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    flush = 1'b0;
    check_idle("t7_flush");
    clear_sb();
    rmode = 1;
    push_frame(22, BEATS);
    for (int k = 0; k < 60 && rq.size() < BEATS; k++) step();
    check("t7_count", DW'(rq.size()), DW'(BEATS));
    check_frame("t7l", 0, 22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
